// File: rtl/gpu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gpu_pkg                                                          |
// | Shared screen geometry and frame-buffer write arbiter types.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package gpu_pkg;

    localparam int SCREEN_W = 480;
    localparam int SCREEN_H = 272;
    localparam int PIXELS   = SCREEN_W * SCREEN_H;
    localparam int IDX_W    = 17;
    localparam int DATA_W   = 9;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARB       = 3'd1,
        DRAIN     = 3'd2,
        COMMIT    = 3'd3,
        WAIT_SWAP = 3'd4
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arbiter                                                       |
// | Round-robin one-hot picker; owns the next-priority pointer.      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] eligible,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // ptr_q is the index searched first: one past the last granted requester.
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] pick;
    logic             found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        pick  = ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && eligible[i] && (PTR_W'(i) >= ptr_q)) begin
                found    = 1'b1;
                pick     = PTR_W'(i);
                grant[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && eligible[i] && (PTR_W'(i) < ptr_q)) begin
                found    = 1'b1;
                pick     = PTR_W'(i);
                grant[i] = 1'b1;
            end
        end
        ptr_d = ptr_q;
        if (advance && found) begin
            ptr_d = (pick == PTR_W'(NUM_REQ - 1)) ? '0 : pick + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fb_write_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fb_write_arbiter                                                 |
// | Shares the frame-buffer pixel port between render engines and   |
// | sequences each frame from buffer-ready to swap request.          |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module fb_write_arbiter
    import gpu_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_en,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*IDX_W-1:0]  req_idx,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        gnt,
    input  logic                      ready,
    output logic                      loaded,
    output logic                      wr_en,
    output logic [IDX_W-1:0]          drawIndex,
    output logic [DATA_W-1:0]         dataIn,
    output logic                      busy,
    output logic [IDX_W-1:0]          frame_pixels,
    output logic [7:0]                drop_cnt
);

    arb_state_t         state_q;
    arb_state_t         state_d;
    logic [NUM_REQ-1:0] done_q;
    logic [NUM_REQ-1:0] done_d;
    logic               wr_en_q;
    logic               wr_en_d;
    logic [IDX_W-1:0]   draw_idx_q;
    logic [IDX_W-1:0]   draw_idx_d;
    logic [DATA_W-1:0]  data_q;
    logic [DATA_W-1:0]  data_d;
    logic [IDX_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   cnt_d;
    logic [IDX_W-1:0]   frame_q;
    logic [IDX_W-1:0]   frame_d;
    logic [7:0]         drop_q;
    logic [7:0]         drop_d;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] rr_grant;
    logic [IDX_W-1:0]   idx_arr  [NUM_REQ];
    logic [DATA_W-1:0]  data_arr [NUM_REQ];
    logic [IDX_W-1:0]   sel_idx;
    logic [DATA_W-1:0]  sel_data;
    logic               any_gnt;
    logic               sel_valid;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign idx_arr[g]  = req_idx[g*IDX_W +: IDX_W];
        assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
    end

    // Only ARB may grant; a low ready freezes arbitration without losing requests.
    assign eligible = (state_q == ARB) ? (req & ~done_q & {NUM_REQ{ready}}) : '0;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk      (clk),
        .reset    (reset),
        .eligible (eligible),
        .advance  (state_q == ARB),
        .grant    (rr_grant)
    );

    always_comb begin
        sel_idx  = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rr_grant[i]) begin
                sel_idx  = idx_arr[i];
                sel_data = data_arr[i];
            end
        end
        any_gnt   = |rr_grant;
        sel_valid = any_gnt && (sel_idx < IDX_W'(PIXELS));
    end

    always_comb begin
        state_d    = state_q;
        done_d     = done_q;
        cnt_d      = cnt_q;
        frame_d    = frame_q;
        loaded     = 1'b0;
        wr_en_d    = sel_valid;
        draw_idx_d = sel_valid ? sel_idx  : draw_idx_q;
        data_d     = sel_valid ? sel_data : data_q;
        drop_d     = drop_q;

        // Out-of-range grants still complete; they are only counted.
        if (any_gnt && !sel_valid && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
        if (sel_valid) begin
            cnt_d = cnt_q + IDX_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (ready) begin
                    state_d = ARB;
                    done_d  = ~req_en;
                    cnt_d   = '0;
                end
            end
            ARB: begin
                done_d = done_q | (rr_grant & req_last);
                if (&done_d) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = COMMIT;
            end
            COMMIT: begin
                loaded  = 1'b1;
                frame_d = cnt_q;
                state_d = WAIT_SWAP;
            end
            WAIT_SWAP: begin
                if (!ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            done_q     <= '0;
            wr_en_q    <= 1'b0;
            draw_idx_q <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            frame_q    <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            wr_en_q    <= wr_en_d;
            draw_idx_q <= draw_idx_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            frame_q    <= frame_d;
            drop_q     <= drop_d;
        end
    end

    assign gnt          = rr_grant;
    assign wr_en        = wr_en_q;
    assign drawIndex    = draw_idx_q;
    assign dataIn       = data_q;
    assign busy         = (state_q != IDLE);
    assign frame_pixels = frame_q;
    assign drop_cnt     = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_write_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fb_write_arbiter                                              |
// | Frame-level bench: requester queues merged round-robin by a      |
// | list model and compared with the observed grant/write streams.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_fb_write_arbiter;

    localparam int N   = 3;
    localparam int IW  = 17;
    localparam int DW  = 9;
    localparam int PIX = 480 * 272;

    typedef struct packed {
        logic [1:0]    who;
        logic [IW-1:0] idx;
        logic [DW-1:0] data;
        logic          last;
    } pix_t;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req_en = '0;
    logic [N-1:0]    req = '0;
    logic [N*IW-1:0] req_idx = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_last = '0;
    logic [N-1:0]    gnt;
    logic            ready = 1'b0;
    logic            loaded;
    logic            wr_en;
    logic [IW-1:0]   drawIndex;
    logic [DW-1:0]   dataIn;
    logic            busy;
    logic [IW-1:0]   frame_pixels;
    logic [7:0]      drop_cnt;

    fb_write_arbiter #(.NUM_REQ(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_en       (req_en),
        .req          (req),
        .req_idx      (req_idx),
        .req_data     (req_data),
        .req_last     (req_last),
        .gnt          (gnt),
        .ready        (ready),
        .loaded       (loaded),
        .wr_en        (wr_en),
        .drawIndex    (drawIndex),
        .dataIn       (dataIn),
        .busy         (busy),
        .frame_pixels (frame_pixels),
        .drop_cnt     (drop_cnt)
    );

    always #10 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    int   model_ptr = 0;
    int   model_drops = 0;
    pix_t pend[$];
    pix_t got_g[$];

    function automatic int head_of(input int r);
        for (int i = 0; i < pend.size(); i++) begin
            if (int'(pend[i].who) == r) return i;
        end
        return -1;
    endfunction

    function automatic void push_pix(input int r, input int idx, input int data, input bit last);
        pix_t p;
        p.who  = 2'(r);
        p.idx  = IW'(idx);
        p.data = DW'(data);
        p.last = last;
        pend.push_back(p);
    endfunction

    // Enabled requesters present their queue head; disabled ones toggle noise.
    task automatic drive_reqs(input logic [N-1:0] en);
        int h;
        for (int r = 0; r < N; r++) begin
            h = head_of(r);
            if (en[r] && h >= 0) begin
                req[r]               = 1'b1;
                req_idx[r*IW +: IW]  = pend[h].idx;
                req_data[r*DW +: DW] = pend[h].data;
                req_last[r]          = pend[h].last;
            end else if (en[r]) begin
                req[r]      = 1'b0;
                req_last[r] = 1'b0;
            end else begin
                req[r]               = 1'($urandom_range(0, 1));
                req_idx[r*IW +: IW]  = IW'($urandom);
                req_data[r*DW +: DW] = DW'($urandom);
                req_last[r]          = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic take_grant(output int who);
        int h;
        who = -1;
        for (int r = 0; r < N; r++) if (gnt[r]) who = r;
        if (who >= 0) begin
            h = head_of(who);
            if (h >= 0) begin
                got_g.push_back(pend[h]);
                pend.delete(h);
            end
        end
    endtask

    task automatic apply_reset;
        @(posedge clk); #1;
        reset = 1'b0;
        ready = 1'b0;
        req   = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        model_ptr   = 0;
        model_drops = 0;
        pend.delete();
    endtask

    // Called just after a rising edge with the DUT idle and ready low.
    task automatic run_frame(input logic [N-1:0] en, input bit rnd, input int stall_from, input string name);
        pix_t        tmp[$];
        pix_t        exp_g[$];
        logic [25:0] exp_w[$];
        logic [25:0] got_w[$];
        int p, r, pick, who, n, ndrop, nvalid;
        int loaded_cyc, loaded_n, last_gnt_cyc;
        bit ok;

        tmp = pend;
        p = model_ptr;
        ndrop = 0;
        nvalid = 0;
        for (int guard = 0; guard < 64; guard++) begin
            pick = -1;
            for (int k = 0; k < N; k++) begin
                r = (p + k) % N;
                if (pick < 0 && en[r]) begin
                    for (int i = 0; i < tmp.size(); i++) begin
                        if (pick < 0 && int'(tmp[i].who) == r) pick = i;
                    end
                end
            end
            if (pick < 0) break;
            exp_g.push_back(tmp[pick]);
            if (int'(tmp[pick].idx) < PIX) begin
                exp_w.push_back({tmp[pick].idx, tmp[pick].data});
                nvalid++;
            end else begin
                ndrop++;
            end
            p = (int'(tmp[pick].who) + 1) % N;
            tmp.delete(pick);
        end

        got_g.delete();
        loaded_cyc = -1;
        loaded_n = 0;
        last_gnt_cyc = -1;
        req_en = en;
        ready = 1'b1;
        drive_reqs(en);
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (loaded) begin
                loaded_n++;
                if (loaded_cyc < 0) loaded_cyc = cyc;
            end
            if (wr_en) got_w.push_back({drawIndex, dataIn});
            if (!ready) begin
                total++;
                if (gnt !== '0) begin
                    bad++;
                    $display("FAIL %s gnt_while_not_ready cyc=%0d got=%b want=000", name, cyc, gnt);
                end
            end
            total++;
            if (!$onehot0(gnt) || ((gnt & ~req) != '0) || ((gnt & ~en) != '0)) begin
                bad++;
                $display("FAIL %s gnt_legal cyc=%0d got=%b req=%b en=%b", name, cyc, gnt, req, en);
            end
            if (gnt != '0) last_gnt_cyc = cyc;
            take_grant(who);
            @(posedge clk); #1;
            n = cyc + 1;
            if (loaded_cyc >= 0) ready = 1'b0;
            else if (stall_from > 0 && n >= stall_from && n < stall_from + 4) ready = 1'b0;
            else if (rnd) ready = ($urandom_range(0, 3) != 0);
            else ready = 1'b1;
            drive_reqs(en);
            if (loaded_cyc >= 0 && cyc >= loaded_cyc + 3) break;
        end

        total++;
        if (loaded_n != 1) begin
            bad++;
            $display("FAIL %s loaded_pulses got=%0d want=1", name, loaded_n);
        end
        ok = (got_g.size() == exp_g.size());
        for (int i = 0; ok && i < exp_g.size(); i++) begin
            if (got_g[i].who != exp_g[i].who || got_g[i].idx != exp_g[i].idx) ok = 1'b0;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s grant_order got_n=%0d want_n=%0d", name, got_g.size(), exp_g.size());
        end
        ok = (got_w.size() == exp_w.size());
        for (int i = 0; ok && i < exp_w.size(); i++) begin
            if (got_w[i] !== exp_w[i]) ok = 1'b0;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s write_stream got_n=%0d want_n=%0d", name, got_w.size(), exp_w.size());
        end
        total++;
        if (frame_pixels !== IW'(nvalid)) begin
            bad++;
            $display("FAIL %s frame_pixels got=%0d want=%0d", name, frame_pixels, nvalid);
        end
        model_drops = (model_drops + ndrop > 255) ? 255 : model_drops + ndrop;
        total++;
        if (drop_cnt !== 8'(model_drops)) begin
            bad++;
            $display("FAIL %s drop_cnt got=%0d want=%0d", name, drop_cnt, model_drops);
        end
        if (exp_g.size() > 0) begin
            total++;
            if (loaded_cyc != last_gnt_cyc + 2) begin
                bad++;
                $display("FAIL %s loaded_timing got=%0d want=%0d", name, loaded_cyc, last_gnt_cyc + 2);
            end
            model_ptr = (int'(exp_g[exp_g.size()-1].who) + 1) % N;
        end else if (!rnd) begin
            total++;
            if (loaded_cyc != 3) begin
                bad++;
                $display("FAIL %s empty_loaded_cycle got=%0d want=3", name, loaded_cyc);
            end
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s busy_after_swap got=%b want=0", name, busy);
        end
        pend.delete();
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total += 8;
        if (gnt !== '0)          begin bad++; $display("FAIL reset gnt got=%b want=0", gnt); end
        if (loaded !== 1'b0)     begin bad++; $display("FAIL reset loaded got=%b want=0", loaded); end
        if (wr_en !== 1'b0)      begin bad++; $display("FAIL reset wr_en got=%b want=0", wr_en); end
        if (drawIndex !== '0)    begin bad++; $display("FAIL reset drawIndex got=%0d want=0", drawIndex); end
        if (dataIn !== '0)       begin bad++; $display("FAIL reset dataIn got=%0d want=0", dataIn); end
        if (busy !== 1'b0)       begin bad++; $display("FAIL reset busy got=%b want=0", busy); end
        if (frame_pixels !== '0) begin bad++; $display("FAIL reset frame_pixels got=%0d want=0", frame_pixels); end
        if (drop_cnt !== '0)     begin bad++; $display("FAIL reset drop_cnt got=%0d want=0", drop_cnt); end
        @(posedge clk); #1 reset = 1'b1;
    endtask

    task automatic test_single;
        push_pix(0, 0, 'h1FF, 0);
        push_pix(0, 1, 'h1FF, 0);
        push_pix(0, 2, 'h1FF, 1);
        run_frame(3'b001, 0, 0, "single");
    endtask

    task automatic test_round_robin;
        apply_reset();
        for (int k = 0; k < 6; k++) push_pix(k % N, 10 * k, k + 1, k >= 3);
        run_frame(3'b111, 0, 0, "round_robin");
    endtask

    task automatic test_disabled;
        run_frame(3'b000, 0, 0, "disabled");
    endtask

    task automatic test_drop;
        push_pix(0, PIX, 'h055, 0);
        push_pix(0, 5, 'h1AB, 1);
        run_frame(3'b001, 0, 0, "drop");
    endtask

    task automatic test_ready_stall;
        for (int k = 0; k < 9; k++) push_pix(k % N, 100 + k, 'h100 + k, k >= 6);
        run_frame(3'b111, 0, 3, "ready_stall");
    endtask

    task automatic test_reset_midframe;
        int who;
        for (int k = 0; k < 12; k++) push_pix(k % N, 200 + k, k, k >= 9);
        req_en = 3'b111;
        ready = 1'b1;
        drive_reqs(3'b111);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            take_grant(who);
            @(posedge clk); #1;
            drive_reqs(3'b111);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if ({gnt, loaded, wr_en, drawIndex, dataIn, busy, frame_pixels, drop_cnt} !== 57'd0) begin
            bad++;
            $display("FAIL midframe_reset outputs got=%h want=0",
                     {gnt, loaded, wr_en, drawIndex, dataIn, busy, frame_pixels, drop_cnt});
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (loaded !== 1'b0 || wr_en !== 1'b0) begin
                bad++;
                $display("FAIL midframe_reset held loaded=%b wr_en=%b want=0", loaded, wr_en);
            end
        end
        @(posedge clk); #1;
        ready = 1'b0;
        reset = 1'b1;
        model_ptr = 0;
        model_drops = 0;
        pend.delete();
        for (int k = 0; k < 4; k++) push_pix(1 + (k % 2), 300 + k, 'h0F0 + k, k >= 2);
        run_frame(3'b110, 0, 0, "after_reset");
    endtask

    task automatic test_random;
        logic [N-1:0] en;
        int n;
        for (int f = 0; f < 10; f++) begin
            en = N'($urandom_range(0, 7));
            for (int r = 0; r < N; r++) begin
                if (en[r]) begin
                    n = $urandom_range(1, 4);
                    for (int j = 0; j < n; j++) begin
                        push_pix(r,
                                 ($urandom_range(0, 7) == 0) ? PIX + $urandom_range(0, 511)
                                                             : $urandom_range(0, PIX - 1),
                                 $urandom_range(0, 511), j == n - 1);
                    end
                end
            end
            run_frame(en, 1, 0, $sformatf("random%0d", f));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_disabled();
        test_drop();
        test_ready_stall();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Shares the single pixel-write port of the double frame buffer between up to NUM_REQ render engines (vertex, line, clear).
- Runs per-frame sequencing:
  - waits for the buffer's ready;
  - grants pixel writes round-robin;
  - collects an end-of-frame mark from every enabled requester;
  - pulses loaded to request the buffer swap at VSync.
- Sits on the CLOCK_50 domain between the render engines and the frame buffer.

Parameters:
NUM_REQ, 3, number of requesters
IDX_W, 17, pixel index width
DATA_W, 9, pixel RGB width (3/3/3)
PIXELS, 130560, valid index count (480x272); indices >= PIXELS are dropped

Ports:
clk  in  1  system clock (CLOCK_50)
reset  in  1  asynchronous, active-low reset
req_en  in  NUM_REQ  requester enable mask, sampled on IDLE->ARB
req  in  NUM_REQ  per-requester write request; held until granted
req_idx  in  NUM_REQ*IDX_W  pixel index per requester
req_data  in  NUM_REQ*DATA_W  pixel data per requester
req_last  in  NUM_REQ  marks a request as that requester's final pixel of the frame
gnt  out  NUM_REQ  one-hot accept, combinational, same cycle as the accepted request
ready  in  1  buffer: back buffer is writable
loaded  out  1  one-cycle pulse: frame complete, swap at next VSync
wr_en  out  1  pixel write strobe to buffer
drawIndex  out  IDX_W  write index
dataIn  out  DATA_W  write data
busy  out  1  state != IDLE
frame_pixels  out  IDX_W  count of writes in last committed frame
drop_cnt  out  8  saturating count of out-of-range indices since reset

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low.
- Reset (reset=0, any time, including mid-frame):
  - state=IDLE, rr pointer=0, done mask=0, pixel counter=0;
  - all outputs 0 (gnt, loaded, wr_en, drawIndex, dataIn, busy, frame_pixels, drop_cnt).
  - Partial frame is abandoned; no loaded is issued.
- States: IDLE, ARB, DRAIN, COMMIT, WAIT_SWAP.
  - IDLE: when ready=1, go to ARB next cycle. Load done mask = ~req_en and clear the pixel counter.
  - ARB:
    - eligible = req & ~done & {NUM_REQ{ready}}.
    - gnt = round-robin pick of eligible, searching from (last granted+1) mod NUM_REQ.
    - If ready=0, no grants; requests stay pending and nothing is lost.
    - Granted with req_last=1: set that requester's done bit. A done requester is never granted again this frame.
    - When next-cycle done mask is all ones, go to DRAIN.
  - DRAIN: one cycle; the final write is on the bus. Go to COMMIT.
  - COMMIT: loaded=1 for exactly this cycle; frame_pixels <= counter. Go to WAIT_SWAP.
  - WAIT_SWAP: wait for ready=0 (buffer has accepted the frame), then go to IDLE. IDLE then waits for ready=1 again.
- Write path:
  - Registered, latency 1. The grant in cycle t produces wr_en/drawIndex/dataIn in cycle t+1.
  - wr_en=1 only if the granted idx < PIXELS. Otherwise the grant still completes (the requester is not stalled), wr_en stays 0, and drop_cnt increments, saturating at 255.
  - drawIndex/dataIn hold their last value when wr_en=0.
  - Counter increments per valid write; it cannot exceed PIXELS in normal use, and wraps at 2^IDX_W.
- rr pointer updates only on a grant. It persists across frames and resets to 0 only on reset.
- All requesters disabled (req_en=0): IDLE->ARB->DRAIN->COMMIT with zero writes; loaded appears 3 cycles after ready is seen.
- Simultaneous req_last from several requesters: each is granted in its own round-robin cycle. loaded follows only after the last of them.
- req asserted while IDLE/DRAIN/COMMIT/WAIT_SWAP: gnt=0; the request waits for the next ARB.

Decomposition:
- Package gpu_pkg holds:
  - arb_state_t enum (IDLE, ARB, DRAIN, COMMIT, WAIT_SWAP);
  - constants SCREEN_W=480, SCREEN_H=272, PIXELS, IDX_W, DATA_W.
- Sub-module rr_arbiter, parameterized by NUM_REQ. Inputs: eligible, advance. Outputs: one-hot grant. It owns the rr pointer. The top module holds the FSM, done mask, write register and counters.

Test Plan:
- Single requester (req_en=001) writes idx 0,1,2 data 0x1FF, last on idx 2 -> wr_en high for 3 cycles with drawIndex 0,1,2; loaded pulses once, one cycle after the final wr_en; frame_pixels=3.
- req_en=111, all three req held continuously, idx=10*k -> gnt order 001,010,100,001,...; each requester sends last on its 2nd grant -> 6 writes, then loaded.
- req_en=000 with ready=1 -> no gnt/wr_en; loaded exactly 3 cycles after ready rises; busy returns 0 after ready drops.
- Requester 0 sends idx=130560 then idx=5 with last -> first grant produces no wr_en and drop_cnt=1; second produces wr_en with drawIndex=5; frame_pixels=1.
- ready forced 0 for 4 cycles mid-ARB with pending requests -> gnt=0 throughout, then resumes in the same round-robin order with no lost pixels; reset pulsed low mid-frame -> all outputs 0 immediately, no loaded, next frame starts clean from IDLE.
